player_controller: RTL and testbench
====================================

Name: player_controller

Overview:
- Tracks the player's vertical position on an 8-row LED column and drives the column image on data_out.
- Moves one row per button press, freezes movement while the player is firing, and handles enemy projectile hits with a hit-flash and a lives counter.
- Sits between the (separately debounced) button inputs and the display multiplexer.

Parameters:
START_POS, 3, row (0..7) loaded into the position register on reset.
LIVES, 3, hits the player can take; reaching 0 means game over. Range 1..7.
FLASH_CYCLES, 8, number of clock cycles spent in the post-hit flash/invulnerable state. Must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset. Asynchronous, active-high.
- button_up  input  1  level from debouncer; a rising edge requests a move up one row.
- button_down  input  1  level from debouncer; a rising edge requests a move down one row.
- is_firing  input  1  high while the player's weapon is firing; blocks movement.
- projectile  input  1  high when an enemy projectile occupies the player's row this cycle (a hit).
- data_out  output  8  column image; bit i lit means row i is lit.
- Positional instantiation order is rst, clk, button_up, button_down, is_firing, projectile, data_out. This order is mandatory.

Behaviour:
- Registers:
  - pos: 3 bits.
  - lives: 3 bits.
  - state: one of ALIVE, HIT, DEAD.
  - flash_cnt: wide enough for FLASH_CYCLES.
  - up_q, dn_q: previous button samples.
- Reset (asynchronous, rst=1):
  - pos=START_POS, lives=LIVES, state=ALIVE, flash_cnt=0, up_q=dn_q=0.
  - data_out = 1<<START_POS, i.e. 8'b0000_1000 with defaults.
- Edge detection:
  - up_rise = button_up & ~up_q; dn_rise = button_down & ~dn_q.
  - up_q and dn_q are updated every cycle in all states.
  - A held button produces exactly one move.
  - A pulse that is not high at any rising clock edge is lost (inputs must be synchronous, at least 1 cycle wide).
- ALIVE:
  - If projectile=1: hit. Priority over movement; no move that cycle.
    - lives decrements.
    - If the new lives value is 0: state->DEAD.
    - Otherwise: state->HIT and flash_cnt=FLASH_CYCLES-1.
  - Else if is_firing=1: no move.
  - Else if up_rise and dn_rise together: no move.
  - Else if up_rise: pos=pos+1, saturating at 7.
  - Else if dn_rise: pos=pos-1, saturating at 0.
- HIT:
  - Movement and projectile are ignored (invulnerable).
  - flash_cnt decrements each cycle; at flash_cnt==0 the next edge returns to ALIVE.
  - Button edges occurring during HIT are discarded, not queued.
- DEAD:
  - All inputs are ignored; only rst leaves this state.
- data_out is decoded purely from registers (no combinational path from inputs):
  - ALIVE: 1<<pos.
  - HIT: 1<<pos when flash_cnt[0]==1, else 8'h00 (blinks).
  - DEAD: 8'hFF.
- Latency: an input sampled at edge N is reflected in data_out immediately after edge N.
- Reset mid-operation, in any state: immediate return to the reset values, independent of clk.

Test Plan:
1. Reset and first move: rst pulse, then button_up high for 1 cycle → data_out 8'h08 after reset, 8'h10 after the sampling edge.
   - button_up held for 5 cycles → only one move, data_out stays 8'h10.
2. Up saturation: from reset, 6 separate 1-cycle up presses with low cycles between → data_out 8'h10, 8'h20, 8'h40, 8'h80, 8'h80, 8'h80.
   - Then 8 down presses → ends at 8'h01 and holds at 8'h01.
3. Firing and simultaneous buttons:
   - is_firing=1 with an up press → data_out unchanged 8'h08.
   - Up and down rising together → unchanged.
   - is_firing=0 with an up press → 8'h10.
4. Hit flash:
   - projectile 1 cycle at pos 3 → lives 2; data_out alternates 8'h08/8'h00 for 8 cycles, then steady 8'h08.
   - Up press and projectile during the flash → ignored; lives stays 2.
5. Game over: three separated hits (each after its flash ends) → after the third, data_out=8'hFF.
   - Buttons and projectile then have no effect.
   - rst → 8'h08 with lives restored.
6. Async reset: assert rst between clock edges while in HIT → data_out becomes 8'h08 before the next clk edge.

Source files
------------

// File: rtl/player_controller.sv
// Player column controller: tracks the player's row on an 8-row LED column,
// applies one-row moves on button rising edges, freezes while firing, and
// handles projectile hits with a blinking invulnerable window and a lives count.
module player_controller #(
    parameter int unsigned START_POS    = 3,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned FLASH_CYCLES = 8
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       button_up,
    input  logic       button_down,
    input  logic       is_firing,
    input  logic       projectile,
    output logic [7:0] data_out
);

    localparam int unsigned FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HIT   = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [2:0]    pos, pos_n;
    logic [2:0]    lives, lives_n;
    logic [FW-1:0] flash_cnt, flash_cnt_n;
    logic          up_q, dn_q;
    logic          up_rise, dn_rise;

    assign up_rise = button_up & ~up_q;
    assign dn_rise = button_down & ~dn_q;

    // State and datapath registers; button samples refresh every cycle in all states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ALIVE;
            pos       <= 3'(START_POS);
            lives     <= 3'(LIVES);
            flash_cnt <= '0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            lives     <= lives_n;
            flash_cnt <= flash_cnt_n;
            up_q      <= button_up;
            dn_q      <= button_down;
        end
    end

    // Next-state logic: hit beats firing, firing beats movement
    always_comb begin
        state_n     = state;
        pos_n       = pos;
        lives_n     = lives;
        flash_cnt_n = flash_cnt;
        unique case (state)
            ALIVE: begin
                if (projectile) begin
                    lives_n = lives - 3'd1;
                    if (lives_n == 3'd0) begin
                        state_n = DEAD;
                    end else begin
                        state_n     = HIT;
                        flash_cnt_n = FW'(FLASH_CYCLES - 1);
                    end
                end else if (is_firing) begin
                    pos_n = pos;
                end else if (up_rise && dn_rise) begin
                    pos_n = pos;
                end else if (up_rise) begin
                    if (pos != 3'd7) pos_n = pos + 3'd1;
                end else if (dn_rise) begin
                    if (pos != 3'd0) pos_n = pos - 3'd1;
                end
            end
            HIT: begin
                if (flash_cnt == '0) begin
                    state_n = ALIVE;
                end else begin
                    flash_cnt_n = flash_cnt - FW'(1);
                end
            end
            DEAD: begin
                state_n = DEAD;
            end
            default: begin
                state_n = ALIVE;
            end
        endcase
    end

    // Column image decoded from registers only; blinks on flash_cnt[0] during HIT
    always_comb begin
        data_out = '0;
        unique case (state)
            ALIVE:   data_out = 8'd1 << pos;
            HIT:     data_out = flash_cnt[0] ? (8'd1 << pos) : 8'h00;
            DEAD:    data_out = 8'hFF;
            default: data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_player_controller.sv
// Directed self-checking bench for player_controller with hand-computed images.
module tb_player_controller;

    logic       rst;
    logic       clk;
    logic       button_up;
    logic       button_down;
    logic       is_firing;
    logic       projectile;
    logic [7:0] data_out;

    int checks;
    int failures;

    player_controller #(
        .START_POS   (3),
        .LIVES       (3),
        .FLASH_CYCLES(8)
    ) dut (
        .rst        (rst),
        .clk        (clk),
        .button_up  (button_up),
        .button_down(button_down),
        .is_firing  (is_firing),
        .projectile (projectile),
        .data_out   (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drive one set of inputs, then sample #1 after the sampling edge
    task automatic cyc(input logic up, input logic dn, input logic fire, input logic proj);
        button_up   = up;
        button_down = dn;
        is_firing   = fire;
        projectile  = proj;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        button_up   = 1'b0;
        button_down = 1'b0;
        is_firing   = 1'b0;
        projectile  = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_up [6]  = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h80, 8'h80};
    logic [7:0] exp_dn [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01};
    logic       t4_up  [11] = '{0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    logic       t4_pr  [11] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] t4_exp [11] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h08, 8'h00,
                                8'h08, 8'h00, 8'h08, 8'h08, 8'h08};

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        button_up = 1'b0;
        button_down = 1'b0;
        is_firing = 1'b0;
        projectile = 1'b0;
        #12;
        check("reset_image", data_out, 8'h08);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset", data_out, 8'h08);

        // 1: first move and held button
        cyc(1, 0, 0, 0);
        check("first_up", data_out, 8'h10);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0);
            check("held_up", data_out, 8'h10);
        end
        cyc(0, 0, 0, 0);
        check("release_up", data_out, 8'h10);

        // 2: saturation both ways
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, 0);
            check("up_sat", data_out, exp_up[i]);
            cyc(0, 0, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0);
            check("dn_sat", data_out, exp_dn[i]);
            cyc(0, 0, 0, 0);
        end
        check("dn_hold", data_out, 8'h01);

        // 3: firing blocks, simultaneous edges cancel
        do_reset();
        cyc(1, 0, 1, 0);
        check("fire_block", data_out, 8'h08);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check("both_edges", data_out, 8'h08);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("up_after_fire", data_out, 8'h10);

        // 4: hit flash with ignored inputs during the flash
        do_reset();
        for (int k = 0; k < 11; k++) begin
            cyc(t4_up[k], 0, 0, t4_pr[k]);
            check("hit_flash", data_out, t4_exp[k]);
        end

        // 5: two more hits leave lives at 0 only if the flash-time hit was ignored
        cyc(0, 0, 0, 1);
        check("hit2", data_out, 8'h08);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        check("hit2_recover", data_out, 8'h08);
        cyc(0, 0, 0, 1);
        check("game_over", data_out, 8'hFF);
        cyc(1, 0, 0, 0);
        check("dead_up", data_out, 8'hFF);
        cyc(0, 1, 0, 1);
        check("dead_dn_proj", data_out, 8'hFF);
        cyc(0, 0, 1, 0);
        check("dead_fire", data_out, 8'hFF);
        do_reset();
        check("dead_reset", data_out, 8'h08);
        cyc(0, 0, 0, 1);
        check("lives_restored", data_out, 8'h08);

        // 6: async reset mid-HIT while the image is blanked
        cyc(0, 0, 0, 0);
        check("hit_blank", data_out, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", data_out, 8'h08);
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        check("post_async", data_out, 8'h08);
        cyc(0, 0, 0, 0);
        check("post_async_steady", data_out, 8'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
